seg7_scan_driver: RTL and testbench

Time-multiplexed driver for the 8-digit, 7-segment display. It is the reading end of the display path. Upstream logic writes hex digits and decimal points into an 8-entry digit register file. This block reads the file back one digit at a time and drives the shared HEX/DP bus and the AN digit selects. Each digit switch is preceded by a dark guard interval to suppress ghosting.

---
 rtl/seg7_scan_driver.sv | 122 ++++++++++++
 tb/tb_seg7_scan_driver.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_driver.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | seg7_scan_driver                                                           |
// | Time-multiplexed 8-digit 7-segment driver with a dark guard in each slot.  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module seg7_scan_driver #(
  parameter int CLK_DIV = 100000,
  parameter int GUARD   = 4
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       we,
  input  logic [2:0] waddr,
  input  logic [3:0] wdata,
  input  logic       wdp,
  input  logic [7:0] blank,
  output logic [7:0] an,
  output logic [6:0] hex,
  output logic       dp,
  output logic       frame
);

  localparam int              c_CW    = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [c_CW-1:0] c_LAST  = c_CW'(CLK_DIV - 1);
  localparam logic [c_CW-1:0] c_GUARD = c_CW'(GUARD);

  logic [c_CW-1:0] r_cnt;
  logic [2:0]      r_idx;
  logic [3:0]      r_val [8];
  logic [7:0]      r_dp;
  logic [7:0]      r_an;
  logic [6:0]      r_hex;
  logic            r_dpo;
  logic            r_frame;

  logic            w_last;
  logic            w_dark;
  logic [3:0]      w_cur;
  logic [6:0]      w_seg;

  assign w_last = (r_cnt == c_LAST);
  assign w_cur  = r_val[r_idx];
  assign w_dark = (r_cnt < c_GUARD) || blank[r_idx];

  // Active-low segment patterns, bit0 = a ... bit6 = g
  always_comb begin
    w_seg = 7'h7F;
    case (w_cur)
      4'h0: w_seg = 7'h40;
      4'h1: w_seg = 7'h79;
      4'h2: w_seg = 7'h24;
      4'h3: w_seg = 7'h30;
      4'h4: w_seg = 7'h19;
      4'h5: w_seg = 7'h12;
      4'h6: w_seg = 7'h02;
      4'h7: w_seg = 7'h78;
      4'h8: w_seg = 7'h00;
      4'h9: w_seg = 7'h10;
      4'hA: w_seg = 7'h08;
      4'hB: w_seg = 7'h03;
      4'hC: w_seg = 7'h46;
      4'hD: w_seg = 7'h21;
      4'hE: w_seg = 7'h06;
      4'hF: w_seg = 7'h0E;
      default: w_seg = 7'h7F;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_cnt <= '0;
      r_idx <= '0;
    end else if (w_last) begin
      r_cnt <= '0;
      r_idx <= r_idx + 3'd1;
    end else begin
      r_cnt <= r_cnt + c_CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      for (int i = 0; i < 8; i++) begin
        r_val[i] <= '0;
      end
      r_dp <= '0;
    end else if (we) begin
      r_val[waddr] <= wdata;
      r_dp[waddr]  <= wdp;
    end
  end

  // Outputs are a pure register of the current slot state, so a live write
  // or BLANK change lands cleanly one edge later without restarting the slot.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_an    <= 8'hFF;
      r_hex   <= 7'h7F;
      r_dpo   <= 1'b1;
      r_frame <= 1'b0;
    end else begin
      r_frame <= w_last && (r_idx == 3'd7);
      if (w_dark) begin
        r_an  <= 8'hFF;
        r_hex <= 7'h7F;
        r_dpo <= 1'b1;
      end else begin
        r_an  <= ~(8'b1 << r_idx);
        r_hex <= w_seg;
        r_dpo <= ~r_dp[r_idx];
      end
    end
  end

  assign an    = r_an;
  assign hex   = r_hex;
  assign dp    = r_dpo;
  assign frame = r_frame;

endmodule
`default_nettype wire

// File: tb/tb_seg7_scan_driver.sv
`default_nettype none
// Bench for seg7_scan_driver: cycle model + scoreboard queue, a reset vector
// table and directed sequences for scan order, live write, blank and reset.
module tb_seg7_scan_driver;

  localparam int CLK_DIV = 8;
  localparam int GUARD   = 2;
  localparam int FRAME_T = 8 * CLK_DIV;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       we = 1'b0;
  logic [2:0] waddr = '0;
  logic [3:0] wdata = '0;
  logic       wdp = 1'b0;
  logic [7:0] blank = '0;
  logic [7:0] an;
  logic [6:0] hex;
  logic       dp;
  logic       frame;

  seg7_scan_driver #(.CLK_DIV(CLK_DIV), .GUARD(GUARD)) dut (
    .clk(clk), .rstn(rstn), .we(we), .waddr(waddr), .wdata(wdata),
    .wdp(wdp), .blank(blank), .an(an), .hex(hex), .dp(dp), .frame(frame)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] an;
    logic [6:0] hex;
    logic       dp;
    logic       frame;
  } exp_t;

  typedef struct {
    logic       rstn;
    int         ncyc;
    logic [7:0] an;
    logic [6:0] hex;
    logic       dp;
  } vec_t;

  logic [6:0] segtab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                              7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
  logic [7:0] an_tab [8] = '{8'hFE, 8'hFD, 8'hFB, 8'hF7, 8'hEF, 8'hDF, 8'hBF, 8'h7F};

  exp_t       sb[$];
  int         m_t = 0;
  logic [3:0] m_val [8];
  logic [7:0] m_dp = '0;

  int         checks = 0;
  int         passed = 0;
  logic [15:0] seen = '0;
  logic       wrap_en = 1'b0;
  int         wrap_runs = 0;
  int         wrap_frames = 0;
  logic [7:0] prev_an = 8'hFF;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act === req) passed++;
    else $display("FAIL %s: got %0h, required %0h", nm, act, req);
  endtask

  // Advance one clock: predict outputs from model state, then compare after the edge.
  task automatic tick();
    exp_t e;
    int   pos;
    int   s;
    logic dark;
    pos = m_t % CLK_DIV;
    s   = (m_t / CLK_DIV) % 8;
    if (!rstn) begin
      e = '{an: 8'hFF, hex: 7'h7F, dp: 1'b1, frame: 1'b0};
    end else begin
      dark    = (pos < GUARD) || blank[s];
      e.an    = dark ? 8'hFF : an_tab[s];
      e.hex   = dark ? 7'h7F : segtab[m_val[s]];
      e.dp    = dark ? 1'b1 : ~m_dp[s];
      e.frame = (pos == CLK_DIV - 1) && (s == 7);
    end
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (!rstn) begin
      m_t = 0;
      for (int i = 0; i < 8; i++) m_val[i] = '0;
      m_dp = '0;
    end else begin
      m_t = (m_t + 1) % FRAME_T;
      if (we) begin
        m_val[waddr] = wdata;
        m_dp[waddr]  = wdp;
      end
    end
    e = sb.pop_front();
    chk("scoreboard", {an, hex, dp, frame}, e);
    chk("an_onehot", ($countones(~an) <= 1), 1);
    for (int i = 0; i < 16; i++)
      if (an != 8'hFF && hex == segtab[i]) seen[i] = 1'b1;
    if (wrap_en) begin
      if (an != 8'hFF && prev_an == 8'hFF) wrap_runs++;
      if (frame) wrap_frames++;
    end
    prev_an = an;
  endtask

  task automatic align(input int tgt);
    int n;
    n = 0;
    while (m_t != tgt && n < 2 * FRAME_T) begin
      tick();
      n++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs [6];
    int   frames;
    int   frame_at;
    int   bad_blank;
    int   lit_total;

    for (int i = 0; i < 8; i++) m_val[i] = '0;
    vecs[0] = '{rstn: 1'b0, ncyc: 5, an: 8'hFF, hex: 7'h7F, dp: 1'b1};
    vecs[1] = '{rstn: 1'b1, ncyc: 0, an: 8'hFF, hex: 7'h7F, dp: 1'b1};
    vecs[2] = '{rstn: 1'b1, ncyc: 2, an: 8'hFF, hex: 7'h7F, dp: 1'b1};
    vecs[3] = '{rstn: 1'b1, ncyc: 1, an: 8'hFE, hex: 7'h40, dp: 1'b1};
    vecs[4] = '{rstn: 1'b1, ncyc: 5, an: 8'hFE, hex: 7'h40, dp: 1'b1};
    vecs[5] = '{rstn: 1'b1, ncyc: 1, an: 8'hFF, hex: 7'h7F, dp: 1'b1};

    for (int i = 0; i < 6; i++) begin
      rstn = vecs[i].rstn;
      repeat (vecs[i].ncyc) tick();
      chk($sformatf("reset_vec%0d", i), {an, hex, dp}, {vecs[i].an, vecs[i].hex, vecs[i].dp});
    end

    // Scan order: digit a shows value a, dp only on digit 5
    for (int a = 0; a < 8; a++) begin
      we = 1'b1; waddr = 3'(a); wdata = 4'(a); wdp = (a == 5);
      tick();
    end
    we = 1'b0; wdp = 1'b0;
    align(0);
    frames = 0;
    frame_at = -1;
    for (int k = 1; k <= FRAME_T; k++) begin
      tick();
      if (frame) begin
        frames++;
        frame_at = k;
      end
      if ((k - 1) % CLK_DIV == 4) begin
        chk($sformatf("scan_slot%0d", (k - 1) / CLK_DIV), {an, hex, dp},
            {an_tab[(k - 1) / CLK_DIV], segtab[(k - 1) / CLK_DIV], ((k - 1) / CLK_DIV) != 5});
      end
    end
    chk("scan_frame_count", frames, 1);
    chk("scan_frame_pos", frame_at, FRAME_T);

    // Live write to the digit currently lit
    align(3 * CLK_DIV + 3);
    chk("live_before", {an, hex}, {8'hF7, 7'h30});
    we = 1'b1; waddr = 3'd3; wdata = 4'hF; wdp = 1'b0;
    tick();
    we = 1'b0;
    chk("live_edge1", {an, hex}, {8'hF7, 7'h30});
    tick();
    chk("live_edge2", {an, hex}, {8'hF7, 7'h0E});

    // Blank digits 1 and 3
    blank = 8'h0A;
    align(0);
    bad_blank = 0;
    lit_total = 0;
    for (int k = 0; k < FRAME_T; k++) begin
      tick();
      if (an != 8'hFF) lit_total++;
      if ((k / CLK_DIV == 1 || k / CLK_DIV == 3) && (an != 8'hFF || hex != 7'h7F)) bad_blank++;
    end
    chk("blank_dark", bad_blank, 0);
    chk("blank_lit_total", lit_total, 6 * (CLK_DIV - GUARD));
    blank = 8'h00;

    // One-cycle reset in the middle of slot 6
    align(6 * CLK_DIV + 4);
    rstn = 1'b0;
    tick();
    chk("midrst_dark", {an, hex, dp, frame}, {8'hFF, 7'h7F, 1'b1, 1'b0});
    rstn = 1'b1;
    tick();
    tick();
    chk("midrst_guard", {an, hex}, {8'hFF, 7'h7F});
    tick();
    chk("midrst_digit0", {an, hex}, {8'hFE, 7'h40});

    // Three frames covering all sixteen values
    align(0);
    wrap_en = 1'b1;
    for (int p = 0; p < 3; p++) begin
      for (int a = 0; a < 8; a++) begin
        we = 1'b1; waddr = 3'(a); wdp = a[0];
        wdata = (p == 0) ? 4'(a) : (p == 1) ? 4'(a + 8) : 4'(15 - a);
        tick();
      end
      we = 1'b0; wdp = 1'b0;
      align(0);
    end
    wrap_en = 1'b0;
    chk("wrap_slots", wrap_runs, 24);
    chk("wrap_frames", wrap_frames, 3);
    chk("seg_coverage", seen, 16'hFFFF);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
`default_nettype wire
